fb_port_arbiter: RTL and testbench

//  Shares one synchronous single-port framebuffer RAM between the ARM data port
//  (absolute priority) and a pixel prefetch engine. The prefetch engine reads

---
 rtl/fb_port_arbiter.sv | 97 +++++++++
 tb/tb_fb_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port framebuffer RAM shared by CPU (priority) and pixel prefetch FIFO
module fb_port_arbiter #(
   parameter int AW    = 16,
   parameter int DW    = 32,
   parameter int NPIX  = 40000,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_re,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   input  logic          enable,
   input  logic          frame_sync,
   input  logic          pix_pop,
   output logic          pix_valid,
   output logic [DW-1:0] pix_data,
   output logic [AW-1:0] fetch_addr,
   output logic          underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]    state;
   logic [DW-1:0] fifo [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          in_flight;
   logic          cpu_req;
   logic          fetch_go;
   logic          do_pop;
   logic [PW+1:0] occupancy;

   // Slots already promised to an outstanding read count as occupied, so the FIFO can never overflow.
   assign cpu_req   = cpu_re | cpu_we;
   assign occupancy = {1'b0, count} + {{(PW + 1){1'b0}}, in_flight};
   assign fetch_go  = !cpu_req && (state == RUN) && (occupancy < (PW + 2)'(DEPTH)) && !frame_sync;
   assign do_pop    = pix_pop && (count != '0);

   assign ram_addr  = cpu_req ? cpu_addr : fetch_addr;
   assign ram_we    = cpu_we;
   assign ram_wdata = cpu_we ? cpu_wdata : '0;
   assign cpu_rdata = ram_rdata;
   assign pix_valid = (count != '0);
   assign pix_data  = pix_valid ? fifo[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fetch_addr <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         in_flight  <= 1'b0;
         underflow  <= 1'b0;
      end else if (frame_sync) begin
         fetch_addr <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         in_flight  <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         state     <= enable ? RUN : IDLE;
         in_flight <= fetch_go;
         if (fetch_go)
            fetch_addr <= (fetch_addr == AW'(NPIX - 1)) ? '0 : fetch_addr + 1'b1;
         if (in_flight)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (pix_pop && (count == '0))
            underflow <= 1'b1;
         case ({in_flight, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: pix_data is masked by pix_valid.
   always_ff @(posedge clk) begin
      if (!reset && !frame_sync && in_flight)
         fifo[wr_ptr] <= ram_rdata;
   end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - randomized check of fb_port_arbiter against a queue-based reference model
module tb_fb_port_arbiter;

   localparam int AW    = 16;
   localparam int DW    = 32;
   localparam int NPIX  = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_re, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          enable, frame_sync, pix_pop;
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic [AW-1:0] fetch_addr;
   logic          underflow;

   always #5 clk = ~clk;

   fb_port_arbiter #(.AW(AW), .DW(DW), .NPIX(NPIX), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .enable(enable), .frame_sync(frame_sync), .pix_pop(pix_pop),
      .pix_valid(pix_valid), .pix_data(pix_data), .fetch_addr(fetch_addr), .underflow(underflow)
   );

   logic [DW-1:0] ram [0:65535];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   // Reference model: memory shadow, pixel queue, pending fetch, frame address.
   logic [DW-1:0] mmem [0:65535];
   logic [DW-1:0] q [$];
   int            m_faddr;
   bit            m_run, m_inflight, m_uf, m_rd_pend, m_known;
   logic [DW-1:0] m_inflight_data, m_rd_exp;
   int            checks = 0;
   int            failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle();
      bit fetch;
      #1;
      fetch = !(cpu_re || cpu_we) && m_run && ((q.size() + int'(m_inflight)) < DEPTH) && !frame_sync;
      if (!reset && m_known) begin
         check_eq("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
         check_eq("pix_data", pix_data, (q.size() != 0) ? q[0] : 32'h0);
         check_eq("fetch_addr", 32'(fetch_addr), m_faddr);
         check_eq("underflow", 32'(underflow), 32'(m_uf));
         if (m_rd_pend) check_eq("cpu_rdata", cpu_rdata, m_rd_exp);
         check_eq("ram_addr", 32'(ram_addr), (cpu_re || cpu_we) ? 32'(cpu_addr) : m_faddr);
         check_eq("ram_we", 32'(ram_we), 32'(cpu_we));
         if (cpu_we) check_eq("ram_wdata", ram_wdata, cpu_wdata);
      end
      m_rd_pend = cpu_re;
      m_rd_exp  = mmem[cpu_addr];
      if (cpu_we) mmem[cpu_addr] = cpu_wdata;
      if (reset) begin
         q.delete(); m_faddr = 0; m_run = 0; m_inflight = 0; m_uf = 0; m_known = 1;
      end else if (frame_sync) begin
         q.delete(); m_faddr = 0; m_inflight = 0; m_uf = 0;
      end else begin
         if (pix_pop) begin
            if (q.size() > 0) q.delete(0);
            else m_uf = 1;
         end
         if (m_inflight) q.push_back(m_inflight_data);
         m_inflight = fetch;
         if (fetch) begin
            m_inflight_data = mmem[m_faddr];
            m_faddr = (m_faddr + 1) % NPIX;
         end
         m_run = enable;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      enable = 0; frame_sync = 0; pix_pop = 0;
   endtask

   task automatic check_reset_vals();
      #1;
      check_eq("rst_pix_valid", 32'(pix_valid), 0);
      check_eq("rst_pix_data", pix_data, 0);
      check_eq("rst_fetch_addr", 32'(fetch_addr), 0);
      check_eq("rst_underflow", 32'(underflow), 0);
      check_eq("rst_ram_we", 32'(ram_we), 0);
      check_eq("rst_ram_addr", 32'(ram_addr), 0);
      check_eq("rst_ram_wdata", ram_wdata, 0);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 65536; i++) begin
         ram[i] = (i < 32) ? $urandom : 32'h0;
         mmem[i] = ram[i];
      end
      m_known = 0; m_run = 0; m_inflight = 0; m_uf = 0; m_rd_pend = 0; m_faddr = 0;
      idle_inputs();
      reset = 1;
      @(negedge clk);
      cycle(); cycle();
      reset = 0;
      check_reset_vals();

      // Startup latency and fill to DEPTH with no consumer.
      enable = 1;
      for (int i = 0; i < 10; i++) cycle();
      check_eq("fill_fetch_addr", 32'(fetch_addr), 4);
      pix_pop = 1; cycle(); pix_pop = 0;
      for (int i = 0; i < 4; i++) cycle();
      check_eq("refill_fetch_addr", 32'(fetch_addr), 5);

      // CPU writes every other cycle interleaved with continuous pops.
      for (int i = 0; i < 40; i++) begin
         cpu_we = (i % 2 == 0); cpu_addr = AW'($urandom_range(0, 31)); cpu_wdata = $urandom;
         pix_pop = 1; cycle();
      end
      idle_inputs(); enable = 1;

      // Continuous pops across several frame wraps, with occasional CPU reads.
      for (int i = 0; i < 40; i++) begin
         cpu_re = ($urandom_range(0, 4) == 0); cpu_addr = AW'($urandom_range(0, 31));
         pix_pop = 1; cycle();
      end
      idle_inputs(); enable = 1;

      // frame_sync while one fetch is in flight and three words are queued.
      frame_sync = 1; cycle(); frame_sync = 0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (q.size() == 3 && m_inflight) found = 1;
         else cycle();
      end
      check_eq("sync_setup", 32'(found), 1);
      frame_sync = 1; cycle(); frame_sync = 0;
      #1;
      check_eq("sync_pix_valid", 32'(pix_valid), 0);
      check_eq("sync_fetch_addr", 32'(fetch_addr), 0);
      for (int i = 0; i < 4; i++) cycle();
      check_eq("sync_first_word", pix_data, mmem[0]);
      pix_pop = 1;
      for (int i = 0; i < 10; i++) cycle();
      pix_pop = 0;

      // Underflow is sticky until frame_sync.
      enable = 0; frame_sync = 1; cycle(); frame_sync = 0;
      pix_pop = 1; cycle(); pix_pop = 0;
      for (int i = 0; i < 3; i++) cycle();
      #1; check_eq("uf_sticky", 32'(underflow), 1);
      frame_sync = 1; cycle(); frame_sync = 0;
      #1; check_eq("uf_cleared", 32'(underflow), 0);

      // Randomized traffic with rare resets and frame syncs.
      for (int i = 0; i < 800; i++) begin
         int r;
         r = $urandom_range(0, 99);
         cpu_re = (r < 15); cpu_we = (r >= 15 && r < 30);
         cpu_addr = AW'($urandom_range(0, 31)); cpu_wdata = $urandom;
         enable = ($urandom_range(0, 9) != 0);
         pix_pop = $urandom_range(0, 1);
         frame_sync = ($urandom_range(0, 49) == 0);
         reset = ($urandom_range(0, 149) == 0);
         cycle();
      end

      // Reset in the middle of a running fetch stream.
      idle_inputs(); reset = 0; enable = 1; pix_pop = 1;
      for (int i = 0; i < 6; i++) cycle();
      reset = 1; cycle();
      reset = 0; idle_inputs(); enable = 1;
      check_reset_vals();
      for (int i = 0; i < 8; i++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
